// File: rtl/conv_pkg.sv
// Shared layer-2 input dimensions and loader FSM state type.
package conv_pkg;

  localparam int BITWIDTH = 8;
  localparam int CHANNELS = 2;
  localparam int ROWS     = 14;
  localparam int COLS     = 14;
  localparam int N        = CHANNELS * ROWS * COLS;

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fmap_state_e;

endpackage

// File: rtl/fmap_raster_cnt.sv
// Channel-major raster counter (ch outer, row, col inner) with enable and
// synchronous clear; flags the final pixel position of the frame.
module fmap_raster_cnt
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CH_W-1:0]  ch,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last_pixel
);

  logic col_wrap;
  logic row_wrap;

  assign col_wrap   = (col == COL_W'(COLS - 1));
  assign row_wrap   = (row == ROW_W'(ROWS - 1));
  assign last_pixel = col_wrap && row_wrap && (ch == CH_W'(CHANNELS - 1));

  // Clear wins over enable so a frame-ending handshake restarts at [0][0][0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch  <= '0;
      row <= '0;
      col <= '0;
    end else if (clr) begin
      ch  <= '0;
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col <= '0;
        if (row_wrap) begin
          row <= '0;
          ch  <= (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmap_loader.sv
// Stream-to-array loader: assembles a CHANNELS x ROWS x COLS feature map from
// a valid/ready pixel stream and holds it until the consumer acknowledges.
module fmap_loader
  import conv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [BITWIDTH-1:0] s_data,
  input  logic                       s_last,
  output logic signed [BITWIDTH-1:0] fmap [CHANNELS][ROWS][COLS],
  output logic                       fmap_valid,
  input  logic                       fmap_ack,
  output logic                       err_len
);

  fmap_state_e state;
  fmap_state_e state_nxt;

  logic             hs;
  logic             cnt_clr;
  logic             last_pixel;
  logic [CH_W-1:0]  ch;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  logic s_ready_d;
  logic fmap_valid_d;
  logic err_len_d;

  assign hs      = s_valid && s_ready && (state == FILL);
  assign cnt_clr = hs && (s_last || last_pixel);

  fmap_raster_cnt u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (hs),
    .clr        (cnt_clr),
    .ch         (ch),
    .row        (row),
    .col        (col),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (hs && last_pixel) state_nxt = HOLD;
      HOLD:    if (fmap_ack)         state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    s_ready_d    = (state_nxt == FILL);
    fmap_valid_d = (state_nxt == HOLD);
    err_len_d    = hs && (s_last != last_pixel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready    <= 1'b0;
      fmap_valid <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      s_ready    <= s_ready_d;
      fmap_valid <= fmap_valid_d;
      err_len    <= err_len_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int r = 0; r < ROWS; r++)
          for (int k = 0; k < COLS; k++)
            fmap[c][r][k] <= '0;
    end else if (hs) begin
      fmap[ch][row][col] <= s_data;
    end
  end

endmodule
